hazard_controller: RTL

- Pipeline sequencing controller for the 5-stage MIPS datapath. It sits beside the operand-forwarding logic and covers the hazards that forwarding cannot resolve.
- Detects load-use hazards and freezes PC and IF/ID for one cycle.
- Squashes wrong-path instructions on a taken branch resolved in EX.
- Sequences a multi-cycle mult/div unit by freezing the front end for its full latency.

---
 rtl/hazard_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: sequencing control for the 5-stage MIPS pipeline.
// It covers the hazards that operand forwarding cannot resolve:
//   - load-use: freezes PC and IF/ID for one cycle and bubbles ID/EX
//   - taken branch resolved in EX: flushes IF/ID and bubbles ID/EX
//   - multi-cycle mult/div: freezes the front end for MD_LATENCY cycles
// Control outputs are combinational from state, counter and inputs.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   IDEXmemRead, IDEXrt  load in ID/EX and its destination register
//   IFIDrs, IFIDrt       source fields of the instruction in IF/ID
//   IFIDusesRt           IF/ID instruction actually reads rt
//   branchTaken          branch in EX resolved taken
//   mdStart              IF/ID holds a mult/div requesting issue
//   pcWrite, IFIDwrite   front-end load enables
//   IFIDflush            zero IF/ID at the next edge
//   IDEXbubble           zero ID/EX control fields at the next edge
//   mdIssue, mdBusy      mult/div accepted / unit occupied
//   mdDone               pulse in the last busy cycle
//   stallCount           cycles with pcWrite==0 (saturating)
//   flushCount           cycles with IFIDflush==1 (saturating)
//
// Build option: define HAZARD_STATS_EN to build the two statistics
// counters; otherwise they are tied to 0 and the ports remain.
module hazard_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEXmemRead,
  input  logic [4:0]  IDEXrt,
  input  logic [4:0]  IFIDrs,
  input  logic [4:0]  IFIDrt,
  input  logic        IFIDusesRt,
  input  logic        branchTaken,
  input  logic        mdStart,
  output logic        pcWrite,
  output logic        IFIDwrite,
  output logic        IFIDflush,
  output logic        IDEXbubble,
  output logic        mdIssue,
  output logic        mdBusy,
  output logic        mdDone,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  typedef enum logic {RUN, MDBUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  // r0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = IDEXmemRead && (IDEXrt != 5'd0) &&
                    ((IDEXrt == IFIDrs) || (IFIDusesRt && (IDEXrt == IFIDrt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        // Branch and load-use both outrank a mult/div issue request.
        if (!branchTaken && !load_use && mdStart) begin
          state_nxt = MDBUSY;
          cnt_nxt   = CNT_W'(MD_LATENCY - 1);
        end
      end
      MDBUSY: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pcWrite    = 1'b1;
    IFIDwrite  = 1'b1;
    IFIDflush  = 1'b0;
    IDEXbubble = 1'b0;
    mdIssue    = 1'b0;
    mdBusy     = 1'b0;
    mdDone     = 1'b0;
    case (state)
      RUN: begin
        if (branchTaken) begin
          IFIDflush  = 1'b1;
          IDEXbubble = 1'b1;
        end else if (load_use) begin
          pcWrite    = 1'b0;
          IFIDwrite  = 1'b0;
          IDEXbubble = 1'b1;
        end else if (mdStart) begin
          mdIssue = 1'b1;
        end
      end
      MDBUSY: begin
        // EX holds the mult/div, so a branch cannot be resolving there.
        mdBusy     = 1'b1;
        pcWrite    = 1'b0;
        IFIDwrite  = 1'b0;
        IDEXbubble = 1'b1;
        // A reset landing on the final busy cycle aborts the operation.
        mdDone     = (cnt == '0) && !rst;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (!pcWrite && (stallCount != 16'hFFFF)) stallCount <= stallCount + 16'd1;
      if (IFIDflush && (flushCount != 16'hFFFF)) flushCount <= flushCount + 16'd1;
    end
  end
`else
  assign stallCount = 16'd0;
  assign flushCount = 16'd0;
`endif

endmodule
